// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage records, forwarding select encodings, register zero.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    // Records are sized for the widest supported register index; narrower
    // REG_W values are zero-extended into these fields at the decode boundary.
    localparam int MAX_REG_W = 8;

    typedef logic [MAX_REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t dest;
        logic     regwrite;
        logic     memread;
    } stage_rec_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    localparam reg_idx_t   REG_ZERO = '0;
    localparam stage_rec_t BUBBLE   = '0;

    // A stage is a usable producer only if it writes a real (non-zero) register.
    function automatic logic produces(input stage_rec_t rec, input reg_idx_t src);
        return rec.regwrite && (rec.dest != REG_ZERO) && (rec.dest == src);
    endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Forwarding select for one EX source operand from the MEM and WB stage records.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from registered state.
module fwd_sel_cmp
    import pipe_pkg::*;
(
    input  logic       ex_valid,
    input  reg_idx_t   ex_src,
    input  stage_rec_t mem_rec,
    input  stage_rec_t wb_rec,
    output logic [1:0] sel
);

    // Only destination and regwrite matter for forwarding; the rest is carried for the pipeline.
    logic unused_fields;
    assign unused_fields = ^{mem_rec.valid, mem_rec.rs, mem_rec.rt, mem_rec.memread,
                             wb_rec.valid, wb_rec.rs, wb_rec.rt, wb_rec.memread};

    // MEM is the younger producer, so it is checked before WB.
    always_comb begin
        sel = SEL_RF;
        if (ex_valid) begin
            if (produces(mem_rec, ex_src)) begin
                sel = SEL_MEM;
            end else if (produces(wb_rec, ex_src)) begin
                sel = SEL_WB;
            end
        end
    end

endmodule

// File: rtl/forward_unit.sv
// EX/MEM/WB hazard tracker: operand forwarding selects and load-use stall with a stall counter.
// Latency: selects and stall are combinational from registered state; records advance each edge.
// Backpressure: stall holds decode for one cycle and injects an EX bubble; flush cancels the stall.
module forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_rec_t       ex_q, ex_d;
    stage_rec_t       mem_q, mem_d;
    stage_rec_t       wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    reg_idx_t id_rs_x, id_rt_x, id_dest_x;
    assign id_rs_x   = reg_idx_t'(id_rs);
    assign id_rt_x   = reg_idx_t'(id_rt);
    assign id_dest_x = reg_idx_t'(id_dest);

    // Load-use hazard: the load in EX has no data yet for the decode instruction; flush wins.
    always_comb begin
        stall = 1'b0;
        if (ex_q.valid && ex_q.memread && (ex_q.dest != REG_ZERO) && id_valid &&
            ((ex_q.dest == id_rs_x) || (ex_q.dest == id_rt_x))) begin
            stall = 1'b1;
        end
        if (flush) begin
            stall = 1'b0;
        end
    end

    // Next stage records: MEM and WB always shift; EX takes decode or a bubble.
    always_comb begin
        mem_d = ex_q;
        wb_d  = mem_q;
        ex_d  = BUBBLE;
        if (id_valid && !stall && !flush) begin
            ex_d.valid    = 1'b1;
            ex_d.rs       = id_rs_x;
            ex_d.rt       = id_rt_x;
            ex_d.dest     = id_dest_x;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
    end

    // Stall counter saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter state; reset turns every stage into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    fwd_sel_cmp u_cmp_a (
        .ex_valid (ex_q.valid),
        .ex_src   (ex_q.rs),
        .mem_rec  (mem_q),
        .wb_rec   (wb_q),
        .sel      (fwd_a_sel)
    );

    fwd_sel_cmp u_cmp_b (
        .ex_valid (ex_q.valid),
        .ex_src   (ex_q.rt),
        .mem_rec  (mem_q),
        .wb_rec   (wb_q),
        .sel      (fwd_b_sel)
    );

endmodule

// File: tb/tb_forward_unit.sv
// Directed bench for forward_unit: vector table for the forwarding and stall scenarios,
// plus hand sequences for mid-stream reset and counter saturation (narrow-counter instance).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_forward_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       id_regwrite, id_memread, flush;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic        s_stall;
    logic [1:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    forward_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    // Same stimulus, 2-bit counter, to reach saturation quickly.
    forward_unit #(.REG_W(5), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_dest     (id_dest),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a_sel   (s_fwd_a_sel),
        .fwd_b_sel   (s_fwd_b_sel),
        .stall       (s_stall),
        .stall_cnt   (s_stall_cnt)
    );

    typedef struct {
        logic        vld;
        logic [4:0]  rs, rt, dest;
        logic        rw, mr, fl;
        logic [1:0]  ea, eb;
        logic        es;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dest, input logic rw, input logic mr,
                                input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                                input logic es, input logic [15:0] ec);
        vec_t v;
        v.vld = vld; v.rs = rs; v.rt = rt; v.dest = dest;
        v.rw = rw; v.mr = mr; v.fl = fl;
        v.ea = ea; v.eb = eb; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Apply one decode slot on the falling edge, then let outputs settle.
    task automatic drive(input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic rw, input logic mr, input logic fl);
        @(negedge clk);
        id_valid = vld; id_rs = rs; id_rt = rt; id_dest = dest;
        id_regwrite = rw; id_memread = mr; flush = fl;
        #1;
    endtask

    initial begin
        // At each step: EX holds the previous slot's instruction (or a bubble).
        tbl[0]  = mk(1, 1, 2, 3, 1, 0, 0,  2'b00, 2'b00, 0, 0);  // add $3
        tbl[1]  = mk(1, 3, 4, 9, 1, 0, 0,  2'b00, 2'b00, 0, 0);  // sub rs=$3
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b10, 2'b00, 0, 0);  // sub in EX: MEM fwd on A
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 0);
        tbl[4]  = mk(1, 10, 11, 5, 1, 0, 0, 2'b00, 2'b00, 0, 0); // writer $5
        tbl[5]  = mk(1, 12, 13, 14, 1, 0, 0, 2'b00, 2'b00, 0, 0); // independent
        tbl[6]  = mk(1, 15, 5, 16, 1, 0, 0, 2'b00, 2'b00, 0, 0);  // reader rt=$5
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b01, 0, 0);  // WB fwd on B
        tbl[8]  = mk(1, 17, 18, 8, 1, 1, 0, 2'b00, 2'b00, 0, 0); // lw $8
        tbl[9]  = mk(1, 8, 19, 20, 1, 0, 0, 2'b00, 2'b00, 1, 0); // add rs=$8: stall
        tbl[10] = mk(1, 8, 19, 20, 1, 0, 0, 2'b00, 2'b00, 0, 1); // held add, bubble in EX
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,  2'b01, 2'b00, 0, 1); // add in EX, lw in WB
        tbl[12] = mk(1, 21, 22, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1); // writer $0
        tbl[13] = mk(1, 23, 24, 0, 1, 1, 0, 2'b00, 2'b00, 0, 1); // load to $0
        tbl[14] = mk(1, 0, 0, 25, 1, 0, 0, 2'b00, 2'b00, 0, 1);  // reader $0: no stall
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 1); // no fwd of $0
        tbl[16] = mk(1, 26, 27, 7, 1, 0, 0, 2'b00, 2'b00, 0, 1); // writer $7 #1
        tbl[17] = mk(1, 28, 29, 7, 1, 0, 0, 2'b00, 2'b00, 0, 1); // writer $7 #2
        tbl[18] = mk(1, 7, 7, 30, 1, 0, 0, 2'b00, 2'b00, 0, 1);  // reader $7
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,  2'b10, 2'b10, 0, 1); // MEM beats WB
        tbl[20] = mk(1, 1, 2, 11, 1, 1, 0, 2'b00, 2'b00, 0, 1);  // lw $11
        tbl[21] = mk(1, 11, 3, 12, 1, 0, 1, 2'b00, 2'b00, 0, 1); // dependent + flush: no stall
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 1); // EX bubble (else A would be 10)
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0,  2'b00, 2'b00, 0, 1);

        id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
        id_regwrite = 0; id_memread = 0; flush = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_fwd_a", 32'(fwd_a_sel), 32'h0);
        chk("reset_fwd_b", 32'(fwd_b_sel), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_cnt", 32'(stall_cnt), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].vld, tbl[i].rs, tbl[i].rt, tbl[i].dest, tbl[i].rw, tbl[i].mr, tbl[i].fl);
            chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a_sel), 32'(tbl[i].ea));
            chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b_sel), 32'(tbl[i].eb));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].es));
            chk($sformatf("v%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].ec));
        end

        // Mid-stream reset with forwarding and a stall both active.
        drive(1, 1, 2, 6, 1, 0, 0);   // writer $6
        drive(1, 6, 2, 13, 1, 1, 0);  // lw $13 reading $6
        drive(1, 13, 0, 15, 1, 0, 0); // uses $13: load-use
        chk("pre_rst_fwd_a", 32'(fwd_a_sel), 32'h2);
        chk("pre_rst_stall", 32'(stall), 32'h1);
        chk("pre_rst_cnt", 32'(stall_cnt), 32'h1);
        chk("pre_rst_sat_cnt", 32'(s_stall_cnt), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_fwd_a", 32'(fwd_a_sel), 32'h0);
        chk("mid_rst_fwd_b", 32'(fwd_b_sel), 32'h0);
        chk("mid_rst_stall", 32'(stall), 32'h0);
        chk("mid_rst_cnt", 32'(stall_cnt), 32'h0);
        chk("mid_rst_sat_cnt", 32'(s_stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First post-reset edge must load EX from decode.
        drive(1, 1, 2, 14, 1, 1, 0);  // lw $14
        drive(1, 14, 3, 16, 1, 0, 0); // dependent
        chk("post_rst_stall", 32'(stall), 32'h1);
        chk("post_rst_cnt0", 32'(stall_cnt), 32'h0);
        drive(1, 14, 3, 16, 1, 0, 0); // held
        chk("post_rst_unstall", 32'(stall), 32'h0);
        chk("post_rst_cnt1", 32'(stall_cnt), 32'h1);

        // Repeated load-use stalls: 16-bit counter keeps counting, 2-bit one pins at 3.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 2, 8, 1, 1, 0);
            drive(1, 8, 8, 20, 1, 0, 0);
            chk($sformatf("sat%0d_stall", k), 32'(s_stall), 32'h1);
            drive(1, 8, 8, 20, 1, 0, 0);
            chk($sformatf("sat%0d_cnt", k), 32'(stall_cnt), 32'(k + 2));
            chk($sformatf("sat%0d_sat_cnt", k), 32'(s_stall_cnt), (k + 2 > 3) ? 32'h3 : 32'(k + 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
